// File: rtl/alu_control_pipe.sv
// Registered, handshaked ALU control decoder: opcode in, ALU operation code out,
// with an issue stall of MC_CYCLES cycles after a multi-cycle operation is handed off.
module alu_control_pipe #(
  parameter int               OPC_W     = 8,
  parameter int               OP_W      = 4,
  parameter logic [OP_W-1:0]  DIS_CODE  = 4'hF,
  parameter logic [OP_W-1:0]  MC_OP     = 4'h8,
  parameter int               MC_CYCLES = 3,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] alu_instruction,
  input  logic             alu_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  alu_operation,
  output logic             illegal_op,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // valid never waits on ready; held data stays stable while valid=1 and ready=0.

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, WAIT = 2'd2} state_t;

  localparam bit MC_ON = (MC_CYCLES != 0);
  localparam int SC_W  = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;

  state_t          state, state_nxt;
  logic [SC_W-1:0] stall_cnt;
  logic            en_q;
  logic [OP_W-1:0] dec_op;
  logic            dec_ill;
  logic            accept, handoff, mc_held;

  assign accept  = in_valid & in_ready;
  assign handoff = out_valid & out_ready;
  assign mc_held = MC_ON && (state == HOLD) && en_q && !illegal_op && (alu_operation == MC_OP);

  // Opcodes compared at full OPC_W width.
  always_comb begin
    dec_op  = '0;
    dec_ill = 1'b0;
    if (!alu_en) begin
      dec_op = DIS_CODE;
    end else begin
      case (alu_instruction)
        OPC_W'('h06): dec_op = OP_W'(0);
        OPC_W'('h07): dec_op = OP_W'(1);
        OPC_W'('h08): dec_op = OP_W'(2);
        OPC_W'('h09): dec_op = OP_W'(3);
        OPC_W'('h0A): dec_op = OP_W'(4);
        OPC_W'('h0B): dec_op = OP_W'(5);
        OPC_W'('h0C): dec_op = OP_W'(6);
        OPC_W'('h0D): dec_op = OP_W'(7);
        OPC_W'('h0F): dec_op = OP_W'(8);
        default:      dec_ill = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = HOLD;
      HOLD: begin
        if (handoff) begin
          if (mc_held)     state_nxt = WAIT;
          else if (accept) state_nxt = HOLD;
          else             state_nxt = IDLE;
        end
      end
      WAIT: if (stall_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~mc_held;
      end
      WAIT: busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_operation <= DIS_CODE;
      illegal_op    <= 1'b0;
      en_q          <= 1'b0;
      stall_cnt     <= '0;
      op_count      <= '0;
    end else begin
      if (accept) begin
        alu_operation <= dec_op;
        illegal_op    <= dec_ill;
        en_q          <= alu_en;
      end
      // Counter holds MC_CYCLES-1 on entry so WAIT lasts exactly MC_CYCLES cycles.
      if (handoff && mc_held)
        stall_cnt <= SC_W'(MC_CYCLES - 1);
      else if (state == WAIT && stall_cnt != '0)
        stall_cnt <= stall_cnt - 1'b1;
      if (handoff && en_q && !illegal_op)
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: doc/alu_control_pipe.md
Name: alu_control_pipe

Overview:
- Registered, handshaked successor to the combinational ALU control decoder.
- Accepts an opcode plus enable on a valid/ready input and decodes it to an ALU operation code.
- Presents the code on a registered valid/ready output and flags illegal opcodes.
- Stalls issue for a programmable number of cycles after a multi-cycle operation. Sits between instruction decode and the ALU datapath.

Parameters:
- OPC_W, 8, opcode width.
- OP_W, 4, ALU operation code width (must be ≥4).
- DIS_CODE, 4'hF, operation code driven when ALU is disabled.
- MC_OP, 4'h8, operation code treated as multi-cycle.
- MC_CYCLES, 3, extra stall cycles after a multi-cycle op is handed off (0 = none).
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  opcode present.
- in_ready  out  1  block can accept opcode.
- alu_instruction  in  OPC_W  opcode.
- alu_en  in  1  ALU enable for this opcode.
- out_valid  out  1  alu_operation/illegal_op valid.
- out_ready  in  1  consumer accepts output.
- alu_operation  out  OP_W  decoded operation code (registered).
- illegal_op  out  1  enabled opcode not in decode table (registered).
- busy  out  1  multi-cycle stall in progress.
- op_count  out  CNT_W  count of legal enabled ops handed off, wraps.

Behaviour:
- Reset: one clock with rst_n=0 at the edge. Forces state=IDLE, out_valid=0, alu_operation=DIS_CODE, illegal_op=0, busy=0, op_count=0, stall counter=0. Reset mid-HOLD/WAIT aborts the operation; the pending output is discarded.
- Decode table (alu_en=1):
  - 0x06→0, 0x07→1, 0x08→2, 0x09→3, 0x0A→4, 0x0B→5, 0x0C→6, 0x0D→7, 0x0F→8.
  - Any other opcode → alu_operation=0, illegal_op=1.
  - Opcodes are zero-extended/compared at full OPC_W.
- alu_en=0: alu_operation=DIS_CODE, illegal_op=0 regardless of opcode. Still a transfer (out_valid asserted).
- Input accept = in_valid & in_ready. Output handoff = out_valid & out_ready.
- FSM states: IDLE, HOLD, WAIT.
  - IDLE:
    - in_ready=1, out_valid=0.
    - On accept: register the decode and go to HOLD. out_valid=1 the next cycle (latency 1).
  - HOLD:
    - out_valid=1. alu_operation/illegal_op stable until handoff; must not change while out_valid=1 and out_ready=0.
    - On handoff with a multi-cycle op (alu_operation==MC_OP, alu_en=1) and MC_CYCLES>0: load stall counter=MC_CYCLES-1 and go to WAIT.
    - On handoff otherwise: return to IDLE, or stay in HOLD if a new input is accepted in the same cycle.
    - in_ready = out_ready & ~(multi-cycle op). This allows back-to-back issue, one op per cycle.
    - If MC_CYCLES=0, a multi-cycle op behaves as a normal op.
  - WAIT:
    - busy=1, in_ready=0, out_valid=0.
    - Counter decrements each cycle. On reaching 0 (that cycle), next state is IDLE.
    - Total stall after handoff = MC_CYCLES cycles with busy=1.
- alu_operation holds its last value when out_valid=0.
- op_count increments by 1 on each handoff where alu_en=1 and illegal_op=0. Wraps 2^CNT_W-1 → 0. Disabled and illegal transfers do not count.
- No combinational path from in_* to out_*; in_ready may depend combinationally on out_ready.

Test Plan:
1. Reset then stimulus: rst_n=0 one cycle → out_valid=0, alu_operation=4'hF, busy=0, op_count=0. Then in_valid=1, alu_en=1, opcode 0x09 with out_ready=1 → next cycle out_valid=1, alu_operation=3, illegal_op=0; op_count=1 after handoff.
2. Back-to-back issue: opcodes 0x06, 0x07, 0x0D streamed with out_ready held 1 → outputs 0, 1, 7 on consecutive cycles, in_ready never drops, op_count=3.
3. Illegal and disabled: opcode 0x05 with alu_en=1 → alu_operation=0, illegal_op=1, op_count unchanged. Opcode 0x06 with alu_en=0 → alu_operation=4'hF, illegal_op=0, op_count unchanged.
4. Backpressure: opcode 0x0B accepted, out_ready=0 for 4 cycles → out_valid=1 and alu_operation=5 held stable, in_ready=0; handoff on cycle 5.
5. Multi-cycle stall: opcode 0x0F with MC_CYCLES=3, then 0x08 offered immediately → alu_operation=8 handed off; busy=1 for exactly 3 cycles with in_ready=0; 0x08 accepted the following cycle → output 2.
6. Reset mid-WAIT and wrap: assert rst_n=0 during busy → next cycle busy=0, state IDLE, op_count=0. With CNT_W=2, issue 5 legal ops → op_count sequence 1, 2, 3, 0, 1.
